// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Brief    : Pipeline enable/flush control for load-use, taken-branch and
//            data-memory-wait hazards in a 5-stage core.
// Revision : 1.0
// ============================================================================
module hazard_stall_ctrl #(
  parameter int REG_W  = 5,
  parameter int CNT_W  = 4,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              mem_err,
  output logic [PERF_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LOAD_USE = 2'd1,
    S_FLUSH    = 2'd2,
    S_MEM_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  c_cnt_max  = '1;
  localparam logic [PERF_W-1:0] c_perf_max = '1;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               r_mem_err;
  logic [PERF_W-1:0]  r_stall_cnt;
  logic               w_load_use;
  logic               w_mem_wait;
  logic               w_cnt_clr;
  logic               w_cnt_inc;
  logic               w_err_set;

  assign w_load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));
  assign w_mem_wait = mem_req && !mem_ready;

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_err_set    = 1'b0;

    if (reset) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else begin
      case (r_state)
        S_MEM_WAIT: begin
          if (mem_ready) begin
            w_next_state = S_RUN;
          end else if (r_wait_cnt == c_cnt_max) begin
            w_err_set    = 1'b1;
            w_next_state = S_RUN;
          end else begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            w_cnt_inc = 1'b1;
          end
        end
        default: begin
          // LOAD_USE releases unconditionally; FLUSH has a bubble in ID, so no load-use there
          if (w_mem_wait) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            w_cnt_clr    = 1'b1;
            w_next_state = S_MEM_WAIT;
          end else if (branch_taken && (r_state != S_LOAD_USE)) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            w_next_state = S_FLUSH;
          end else if (w_load_use && (r_state == S_RUN)) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_flush  = 1'b1;
            w_next_state = S_LOAD_USE;
          end else begin
            w_next_state = S_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_cnt_clr) begin
        r_wait_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_err_set) begin
        r_mem_err <= 1'b1;
      end
      if (!pc_en && (r_stall_cnt != c_perf_max)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Brief    : Directed self-checking bench for hazard_stall_ctrl (CNT_W=2, PERF_W=4).
// Revision : 1.0
// ============================================================================
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read;
  logic       branch_taken, mem_req, mem_ready;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic       ex_mem_en, mem_wb_en, mem_err;
  logic [3:0] stall_cnt;

  hazard_stall_ctrl #(.REG_W(5), .CNT_W(2), .PERF_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_en     (id_ex_en),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
  localparam logic [6:0] c_def = 7'b1101011;
  localparam logic [6:0] c_lu  = 7'b0001111;
  localparam logic [6:0] c_br  = 7'b1111111;
  localparam logic [6:0] c_off = 7'b0000000;

  typedef struct packed {
    logic [6:0] ctrl;
    logic       err;
    logic [3:0] stall;
  } exp_t;

  exp_t       sb_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [3:0] exp_stall = 4'd0;
  logic       exp_err   = 1'b0;

  task automatic step(input string tag, input bit rst,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u1, input bit u2, input bit mrd, input logic [4:0] rd,
                      input bit br, input bit mreq, input bit mrdy,
                      input logic [6:0] ctrl, input bit err_set);
    exp_t e, o;
    @(negedge clk);
    reset = rst; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_mem_read = mrd; ex_rd = rd; branch_taken = br; mem_req = mreq; mem_ready = mrdy;
    sb_q.push_back('{ctrl: ctrl, err: exp_err, stall: exp_stall});
    #2;
    e = sb_q.pop_front();
    o.ctrl  = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};
    o.err   = mem_err;
    o.stall = stall_cnt;
    tests++;
    assert (o.ctrl === e.ctrl) else begin
      fails++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, o.ctrl, e.ctrl);
    end
    tests++;
    assert (o.err === e.err) else begin
      fails++;
      $error("FAIL %s mem_err observed=%b expected=%b", tag, o.err, e.err);
    end
    tests++;
    assert (o.stall === e.stall) else begin
      fails++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, o.stall, e.stall);
    end
    if (rst) begin
      exp_stall = 4'd0;
      exp_err   = 1'b0;
    end else begin
      if (!ctrl[6] && exp_stall != 4'hF) exp_stall = exp_stall + 4'd1;
      if (err_set) exp_err = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk);

    //    tag          rst rs1 rs2 u1 u2 mrd rd br mq mr ctrl   err
    step("reset",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_off, 0);
    step("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_def, 0);
    step("lu_rs1",     0, 5, 0, 1, 0, 1, 5, 0, 0, 0, c_lu,  0);
    step("lu_release", 0, 5, 0, 1, 0, 1, 5, 0, 0, 0, c_def, 0);
    step("rd_x0",      0, 0, 0, 1, 0, 1, 0, 0, 0, 0, c_def, 0);
    step("rs2_unused", 0, 0, 7, 0, 0, 1, 7, 0, 0, 0, c_def, 0);
    step("lu_rs2",     0, 0, 7, 0, 1, 1, 7, 0, 0, 0, c_lu,  0);
    step("lu_release2",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_def, 0);
    step("branch",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_br,  0);
    step("flush_nolu", 0, 5, 0, 1, 0, 1, 5, 0, 0, 0, c_def, 0);
    step("lu_after_fl",0, 5, 0, 1, 0, 1, 5, 0, 0, 0, c_lu,  0);
    step("lu_release3",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_def, 0);
    step("branch2",    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_br,  0);
    step("branch_fl",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_br,  0);
    step("flush_exit", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_def, 0);
    step("mw_enter",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_off, 0);
    step("mw_wait1",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_off, 0);
    step("mw_wait2",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_off, 0);
    step("mw_ready",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, c_def, 0);
    step("mw_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_def, 0);
    step("prio_all",   0, 5, 0, 1, 0, 1, 5, 1, 1, 0, c_off, 0);
    step("mw_br_ign",  0, 5, 0, 1, 0, 1, 5, 1, 1, 0, c_off, 0);
    step("rdy_ign_hz", 0, 5, 0, 1, 0, 1, 5, 1, 1, 1, c_def, 0);
    step("prio_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_def, 0);
    step("to_enter",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_off, 0);
    step("to_cnt0",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_off, 0);
    step("to_cnt1",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_off, 0);
    step("to_cnt2",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_off, 0);
    step("to_fire",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_def, 1);
    step("to_resume",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_def, 0);
    step("sat_enter",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_off, 0);
    step("sat_cnt0",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_off, 0);
    step("sat_cnt1",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_off, 0);
    step("sat_cnt2",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_off, 0);
    step("sat_fire",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_def, 1);
    step("sat_reenter",0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_off, 0);
    step("rst_in_mw",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_off, 0);
    step("rst_hold",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_off, 0);
    step("post_rst",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_def, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control block that drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- It is the controlling end of the register enable/bubble interface: it decides each cycle which stages advance, hold or get cleared.
- It resolves three hazards: load-use, taken branch (bc) and a multi-cycle data-memory wait with a ready handshake.
- It sits beside the datapath in the 5-stage RISC-V core and is fed from the ID, EX/MEM and MEM stages.

Parameters:
REG_W, 5, register index width (rs1/rs2/rd)
CNT_W, 4, width of the memory-wait timeout counter; timeout = 2^CNT_W-1 wait cycles
PERF_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
id_rs1  input  REG_W  rs1 index of instruction in ID
id_rs2  input  REG_W  rs2 index of instruction in ID
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
ex_mem_read  input  1  instruction in EX is a load
ex_rd  input  REG_W  destination of instruction in EX
branch_taken  input  1  taken branch/jump resolved (bc), one-cycle pulse
mem_req  input  1  MEM-stage instruction accesses data memory this cycle
mem_ready  input  1  data memory response valid / access complete
pc_en  output  1  PC write enable
if_id_en  output  1  IF/ID enable
if_id_flush  output  1  IF/ID clear to bubble
id_ex_en  output  1  ID/EX enable
id_ex_flush  output  1  ID/EX clear to bubble
ex_mem_en  output  1  EX/MEM enable
mem_wb_en  output  1  MEM/WB enable
mem_err  output  1  sticky memory-timeout flag
stall_cnt  output  PERF_W  saturating count of cycles with pc_en=0

Behaviour:
- Reset (clk edge with reset=1): state=RUN, wait counter=0, mem_err=0, stall_cnt=0. While reset=1 all *_en=0 and all *_flush=0. Reset mid-MEM_WAIT abandons the access.
- Control outputs are combinational from state and current inputs; a stall takes effect in the same cycle its condition is seen.
- States: RUN, LOAD_USE, FLUSH, MEM_WAIT. Default outputs: all enables=1, flushes=0.
- Hazard priority: memory wait > taken branch > load-use.
- Load-use hazard: ex_mem_read=1, ex_rd!=0, and ((id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd)).
- Memory wait condition: mem_req=1 and mem_ready=0.
- RUN, memory wait condition true: all five enables=0, no flush. Next state MEM_WAIT, counter cleared.
- RUN, branch_taken=1: if_id_flush=1, id_ex_flush=1, enables 1. Next state FLUSH.
- RUN, load-use hazard: pc_en=0, if_id_en=0, id_ex_flush=1, rest 1. Next state LOAD_USE.
- RUN, otherwise: stay RUN.
- LOAD_USE: default outputs for exactly one cycle, then RUN. A memory wait in this cycle takes priority exactly as in RUN.
- FLUSH: load-use detection suppressed because ID holds a bubble. A second branch_taken flushes again and stays in FLUSH; otherwise go to RUN. A memory wait takes priority.
- MEM_WAIT: all enables=0; mem_req is held stable by the frozen EX/MEM register.
- MEM_WAIT, mem_ready=1: default outputs, branch/load-use ignored this cycle, then RUN.
- MEM_WAIT, counter==2^CNT_W-1 without mem_ready: set mem_err (sticky until reset), default outputs, then RUN.
- MEM_WAIT, otherwise: counter +1 per cycle.
- branch_taken arriving while in MEM_WAIT is ignored. The branching instruction is frozen in EX/MEM and re-presents bc after release.
- stall_cnt: +1 on every non-reset cycle with pc_en=0; saturates at all-ones with no wrap.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> same cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1, stall_cnt=1.
- rd=x0 and unused operand: ex_rd=0 with matching rs1, then ex_rd=7, id_rs2=7, id_use_rs2=0 -> no stall in either case.
- Branch then load-use: branch_taken pulse -> both flushes=1; next cycle a load-use match -> no stall (FLUSH state); following cycle with match -> stall.
- Memory wait: mem_req=1, mem_ready low 3 cycles then high -> enables 0 for 3 cycles, 1 on ready cycle, stall_cnt=3.
- Timeout with CNT_W=2: mem_ready never asserted -> mem_err=1 after 3 wait cycles and flow resumes; reset asserted -> mem_err=0, stall_cnt=0, enables 0 while reset=1.
- Priority: mem wait, branch_taken and load-use in the same RUN cycle -> MEM_WAIT behaviour only, no flush.
